// File: rtl/ppc_bus_arbiter.sv
// rtl/ppc_bus_arbiter.sv - 60x-style bus arbiter: round-robin address grants, queued data tenures
module ppc_bus_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int QDEPTH        = 2,
    parameter int GRANT_TIMEOUT = 15
) (
    input  logic                   CLK,
    input  logic                   HRESET_N,
    input  logic [0:NUM_MASTERS-1] BR,
    input  logic                   TS,
    input  logic [0:4]             TT,
    input  logic                   TBST,
    input  logic                   AACK,
    input  logic                   ARTRY,
    input  logic                   TA,
    output logic [0:NUM_MASTERS-1] BG,
    output logic [0:NUM_MASTERS-1] DBG,
    output logic                   ABUSY,
    output logic                   QFULL
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

    typedef enum logic [1:0] {A_IDLE, A_GRANT, A_TENURE, A_RTRY} a_state_t;
    typedef enum logic [1:0] {D_IDLE, D_GRANT, D_XFER} d_state_t;

    a_state_t a_state, a_next;
    d_state_t d_state, d_next;

    logic [IW-1:0]          ptr, gnt_id, ten_id, pick_id, bg_sel, idx_v;
    logic                   any_req, ten_burst, ten_data, tmo_done;
    logic [TW-1:0]          tmo_cnt;
    logic [0:NUM_MASTERS-1] bg_d, dbg_d, bg_q, dbg_q;
    int                     idx;

    logic [IW-1:0] q_id    [QDEPTH];
    logic          q_burst [QDEPTH];
    logic [QW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, push_ok, pop, empty;
    logic [2:0]    beat_cnt;

    // Address-only/other TT bits carry no meaning for arbitration
    logic unused_tt;
    assign unused_tt = ^{TT[0:2], TT[4]};

    // Scan ptr+1 .. ptr+N; iterating downwards lets the nearest requester win
    always_comb begin
        any_req = 1'b0;
        pick_id = '0;
        idx     = 0;
        idx_v   = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            idx_v = IW'(idx);
            if (!BR[idx_v]) begin
                any_req = 1'b1;
                pick_id = idx_v;
            end
        end
    end

    assign tmo_done = (tmo_cnt == TW'(GRANT_TIMEOUT - 1));

    always_ff @(posedge CLK or negedge HRESET_N) begin
        if (!HRESET_N) begin
            a_state   <= A_IDLE;
            ptr       <= '0;
            gnt_id    <= '0;
            ten_id    <= '0;
            ten_burst <= 1'b0;
            ten_data  <= 1'b0;
            tmo_cnt   <= '0;
            bg_q      <= '1;
        end else begin
            a_state <= a_next;
            bg_q    <= bg_d;
            tmo_cnt <= (a_state == A_GRANT) ? tmo_cnt + 1'b1 : '0;
            if (a_state == A_IDLE && a_next == A_GRANT)
                gnt_id <= pick_id;
            if (a_state == A_GRANT && !TS) begin
                ptr       <= gnt_id;
                ten_id    <= gnt_id;
                ten_burst <= !TBST;
                ten_data  <= TT[3];
            end
        end
    end

    always_comb begin
        a_next = a_state;
        case (a_state)
            A_IDLE:   if (any_req && !QFULL) a_next = A_GRANT;
            A_GRANT: begin
                if (!TS)              a_next = A_TENURE;
                else if (BR[gnt_id])  a_next = A_IDLE;
                else if (tmo_done)    a_next = A_IDLE;
            end
            A_TENURE: if (!AACK) a_next = A_RTRY;
            A_RTRY:   a_next = A_IDLE;
            default:  a_next = A_IDLE;
        endcase
    end

    always_comb begin
        bg_sel = (a_state == A_IDLE) ? pick_id : gnt_id;
        bg_d   = '1;
        if (a_next == A_GRANT) bg_d[bg_sel] = 1'b0;
        ABUSY  = (a_state == A_TENURE) || (a_state == A_RTRY);
        push   = (a_state == A_RTRY) && ARTRY && ten_data;
    end

    // Pending data tenures, one entry per accepted address tenure
    assign empty   = (count == '0);
    assign QFULL   = (count == CW'(QDEPTH));
    assign push_ok = push && (!QFULL || pop);

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            q_id[wr_ptr]    <= ten_id;
            q_burst[wr_ptr] <= ten_burst;
        end
    end

    always_ff @(posedge CLK or negedge HRESET_N) begin
        if (!HRESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == QW'(QDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)     rd_ptr <= (rd_ptr == QW'(QDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge HRESET_N) begin
        if (!HRESET_N) begin
            d_state  <= D_IDLE;
            beat_cnt <= '0;
            dbg_q    <= '1;
        end else begin
            d_state <= d_next;
            dbg_q   <= dbg_d;
            if (d_state == D_IDLE && d_next == D_GRANT)
                beat_cnt <= q_burst[rd_ptr] ? 3'd4 : 3'd1;
            else if (d_state != D_IDLE && !TA)
                beat_cnt <= beat_cnt - 1'b1;
        end
    end

    always_comb begin
        d_next = d_state;
        case (d_state)
            D_IDLE:  if (!empty) d_next = D_GRANT;
            D_GRANT: if (!TA) d_next = (beat_cnt == 3'd1) ? D_IDLE : D_XFER;
            D_XFER:  if (!TA && beat_cnt == 3'd1) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    always_comb begin
        pop   = (d_state != D_IDLE) && !TA && (beat_cnt == 3'd1);
        dbg_d = '1;
        if (d_next == D_GRANT) dbg_d[q_id[rd_ptr]] = 1'b0;
    end

    assign BG  = bg_q;
    assign DBG = dbg_q;

endmodule

// File: tb/tb_ppc_bus_arbiter.sv
// tb/tb_ppc_bus_arbiter.sv - directed self-checking bench for ppc_bus_arbiter
module tb_ppc_bus_arbiter;

    logic       CLK = 1'b0;
    logic       HRESET_N;
    logic [0:1] BR;
    logic       TS;
    logic [0:4] TT;
    logic       TBST, AACK, ARTRY, TA;
    logic [0:1] BG, DBG;
    logic       ABUSY, QFULL;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    ppc_bus_arbiter #(
        .NUM_MASTERS  (2),
        .QDEPTH       (2),
        .GRANT_TIMEOUT(15)
    ) dut (
        .CLK     (CLK),
        .HRESET_N(HRESET_N),
        .BR      (BR),
        .TS      (TS),
        .TT      (TT),
        .TBST    (TBST),
        .AACK    (AACK),
        .ARTRY   (ARTRY),
        .TA      (TA),
        .BG      (BG),
        .DBG     (DBG),
        .ABUSY   (ABUSY),
        .QFULL   (QFULL)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        HRESET_N = 1'b0;
        BR = 2'b11; TS = 1'b1; TT = 5'b00010; TBST = 1'b1;
        AACK = 1'b1; ARTRY = 1'b1; TA = 1'b1;
        step(); step();
        chk("rst_bg", BG, 2'b11);
        chk("rst_dbg", DBG, 2'b11);
        chk("rst_abusy", ABUSY, 1'b0);
        chk("rst_qfull", QFULL, 1'b0);
        HRESET_N = 1'b1;
        step();

        // single beat from master 0
        BR = 2'b01;
        step(); chk("sb_bg", BG, 2'b01);
        TS = 1'b0; BR = 2'b11;
        step(); chk("sb_bg_off", BG, 2'b11); chk("sb_abusy", ABUSY, 1'b1);
        TS = 1'b1; AACK = 1'b0;
        step(); chk("sb_abusy2", ABUSY, 1'b1);
        AACK = 1'b1;
        step(); chk("sb_abusy_off", ABUSY, 1'b0); chk("sb_dbg_nobypass", DBG, 2'b11);
        step(); chk("sb_dbg", DBG, 2'b01);
        step(); chk("sb_dbg_hold", DBG, 2'b01);
        TA = 1'b0;
        step(); chk("sb_dbg_off", DBG, 2'b11);
        TA = 1'b1;
        step(); chk("sb_q_empty", DBG, 2'b11);

        // round-robin with bursts; queue fills and blocks grants
        BR = 2'b00; TBST = 1'b0;
        step(); chk("rr_g1", BG, 2'b10);
        TS = 1'b0;
        step(); chk("rr_g1_off", BG, 2'b11);
        TS = 1'b1; AACK = 1'b0;
        step();
        AACK = 1'b1;
        step(); chk("rr_qfull0", QFULL, 1'b0);
        step(); chk("rr_g0", BG, 2'b01); chk("rr_dbg1", DBG, 2'b10);
        TS = 1'b0;
        step(); chk("rr_g0_off", BG, 2'b11); chk("rr_dbg1_hold", DBG, 2'b10);
        TS = 1'b1; AACK = 1'b0;
        step();
        AACK = 1'b1;
        step(); chk("pl_qfull", QFULL, 1'b1);
        step(); chk("pl_blocked", BG, 2'b11);
        TA = 1'b0;
        step(); chk("pl_dbg_off", DBG, 2'b11);
        step();
        step(); chk("pl_qfull_3ta", QFULL, 1'b1);
        step(); chk("pl_qfull_4ta", QFULL, 1'b0);
        TA = 1'b1;
        step(); chk("pl_g1", BG, 2'b10); chk("pl_dbg0", DBG, 2'b01);
        BR = 2'b11;
        step(); chk("pl_withdraw", BG, 2'b11);
        TA = 1'b0;
        for (int i = 0; i < 4; i++) step();
        TA = 1'b1;
        step(); chk("pl_drained", DBG, 2'b11);

        // retry: no data tenure, master 0 regains bus
        BR = 2'b01; TBST = 1'b1;
        step(); chk("rt_bg", BG, 2'b01);
        TS = 1'b0; BR = 2'b11;
        step(); chk("rt_abusy", ABUSY, 1'b1);
        TS = 1'b1; AACK = 1'b0;
        step();
        AACK = 1'b1; ARTRY = 1'b0;
        step(); chk("rt_abusy_off", ABUSY, 1'b0);
        ARTRY = 1'b1;
        step(); chk("rt_no_dbg", DBG, 2'b11);
        step(); chk("rt_no_dbg2", DBG, 2'b11);
        BR = 2'b01;
        step(); chk("rt_regrant", BG, 2'b01);
        BR = 2'b11;
        step(); chk("rt_release", BG, 2'b11);

        // grant timeout on master 1
        BR = 2'b10;
        step(); chk("to_bg", BG, 2'b10);
        for (int i = 0; i < 14; i++) step();
        chk("to_hold", BG, 2'b10);
        step(); chk("to_withdraw", BG, 2'b11);
        step(); chk("to_regrant", BG, 2'b10);
        BR = 2'b11;
        step(); chk("to_release", BG, 2'b11);

        // asynchronous reset with BG and DBG both active
        BR = 2'b01; TBST = 1'b0;
        step(); chk("rs_bg0", BG, 2'b01);
        TS = 1'b0; BR = 2'b11;
        step();
        TS = 1'b1; AACK = 1'b0;
        step();
        AACK = 1'b1; BR = 2'b10;
        step();
        step(); chk("rs_bg1", BG, 2'b10); chk("rs_dbg0", DBG, 2'b01);
        #3 HRESET_N = 1'b0;
        #1;
        chk("rs_async_bg", BG, 2'b11);
        chk("rs_async_dbg", DBG, 2'b11);
        chk("rs_async_qfull", QFULL, 1'b0);
        BR = 2'b11;
        step();
        HRESET_N = 1'b1;
        step(); chk("rs_post_dbg", DBG, 2'b11); chk("rs_post_bg", BG, 2'b11);
        TA = 1'b0;
        step(); chk("rs_stray_ta", DBG, 2'b11);
        TA = 1'b1; BR = 2'b00;
        step(); chk("rs_ptr0", BG, 2'b10);
        BR = 2'b11;
        step(); chk("rs_end", BG, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppc_bus_arbiter.md
Name: ppc_bus_arbiter

Overview:
- Central arbiter for the 60x-style processor bus in front of the memory controller.
- Shares the address bus and the data bus between NUM_MASTERS bus masters through BR/BG (address tenure) and DBG (data tenure).
- Pipelines up to QDEPTH accepted address tenures awaiting data.
- Observes the slave handshake (TS, AACK, ARTRY, TA) and never drives it.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- QDEPTH, 2, outstanding data tenures queued (1..4).
- GRANT_TIMEOUT, 15, cycles a qualified BG may go unused before being withdrawn.

Ports:
- CLK  input  1  bus clock; all sampling on the rising edge.
- HRESET_N  input  1  asynchronous active-low reset.
- BR  input  [0:NUM_MASTERS-1]  bus requests, active low.
- TS  input  1  transfer start, active low, driven by the granted master.
- TT  input  [0:4]  transfer type; TT[3]=0 marks an address-only transfer.
- TBST  input  1  active low; 0 means a 4-beat burst, 1 means a single beat.
- AACK  input  1  address acknowledge from the slave, active low.
- ARTRY  input  1  address retry, active low; valid only in the cycle after AACK.
- TA  input  1  transfer acknowledge per data beat, active low.
- BG  output  [0:NUM_MASTERS-1]  address bus grants, active low, registered.
- DBG  output  [0:NUM_MASTERS-1]  data bus grants, active low, registered.
- ABUSY  output  1  high while an address tenure is in progress.
- QFULL  output  1  high when QDEPTH entries are pending.

Behaviour:
- Reset (async, HRESET_N=0):
  - BG and DBG all 1. ABUSY=0, QFULL=0.
  - Queue empty. Round-robin pointer = master 0. Timeout counter = 0. Both FSMs idle.
- Address FSM states: A_IDLE, A_GRANT, A_TENURE, A_RTRY.
- A_IDLE:
  - If any BR bit is 0 and QFULL=0, pick the first requester in round-robin order starting at pointer+1 (wrapping).
  - Drive its BG=0 in the next cycle and go to A_GRANT.
  - No request: all BG stay 1 (no parking).
- A_GRANT:
  - TS=0 sampled: BG to all 1 next cycle, ABUSY=1, latch granted id and TBST/TT, pointer := id, go to A_TENURE.
  - Granted BR returns to 1 before TS: withdraw BG, go to A_IDLE.
  - GRANT_TIMEOUT cycles elapse without TS: withdraw BG, go to A_IDLE. Counter restarts on every new grant.
- A_TENURE: on AACK=0, go to A_RTRY.
- A_RTRY (the ARTRY window cycle):
  - ARTRY=0: discard the tenure. Nothing is queued. Pointer is unchanged.
  - ARTRY=1 and TT[3]=1: push {id, beats} into the queue; beats is 4 if latched TBST=0, else 1.
  - ARTRY=1 and TT[3]=0: nothing is pushed.
  - In all cases: ABUSY=0, go to A_IDLE.
  - The earliest next BG is the cycle after A_RTRY.
- Data FSM states: D_IDLE, D_GRANT, D_XFER.
- D_IDLE:
  - If the queue is non-empty, drive DBG[head.id]=0 next cycle, load the beat counter from head.beats, go to D_GRANT.
  - A push and a non-empty check in the same cycle: the pushed entry is visible the following cycle. There is no bypass.
- D_GRANT:
  - DBG stays asserted until the first TA=0.
  - In that same cycle DBG returns to 1, the counter decrements, and the FSM goes to D_XFER.
  - If the counter reached 0, it goes straight to pop.
- D_XFER: each TA=0 decrements the counter. When the counter reaches 0, pop the head and go to D_IDLE.
- TA outside a data tenure is ignored.
- Simultaneous push and pop in one cycle: both take effect and the count is unchanged.
- QFULL = (count==QDEPTH). It blocks new grants only; a tenure already in progress completes.
- At most one BG bit and at most one DBG bit are 0 in any cycle.
- Reset mid-tenure: everything returns to reset values asynchronously. Queued entries are lost.

Test Plan:
- Single beat: BR[0]=0, TS at grant+1, AACK, ARTRY=1, TBST=1, TT=5'b00010.
  - Expect BG[0]=0 one cycle after BR is sampled, then 1 after TS.
  - Expect DBG[0]=0 two cycles after the window, then 1 after one TA. Queue empty after.
- Round-robin: BR[0] and BR[1] held at 0 continuously.
  - Grants alternate 0,1,0,1.
  - Burst (TBST=0) data tenures each consume exactly 4 TA.
- Retry: AACK followed by ARTRY=0 in the window.
  - No DBG is issued.
  - The same master regains BG on its next request, since the pointer is unchanged.
- Pipelining with QDEPTH=2: two accepted bursts with TA withheld.
  - QFULL=1 and BR[0]=0 receives no BG.
  - After 4 TA, QFULL=0, DBG moves to the second entry, and BG is granted.
- Timeout: BR[1]=0 but TS never asserted.
  - BG[1] is withdrawn after 15 cycles, then re-granted.
- Reset: HRESET_N pulsed low mid-burst, between CLK edges.
  - BG and DBG are all 1 immediately. Queue is empty and the FSMs are idle after release.
